uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Downstream consumer of the UART receive stage.
- Turns received ASCII keystrokes into minesweeper cursor moves and game commands.
- Maintains the board cursor and queues action commands (open / flag / new game), tagged with the cursor position, in a small FIFO.
- The game engine drains that FIFO through a valid/ready handshake.

Parameters:
- ROWS, 8, board rows; cursor row range 0..ROWS-1.
- COLS, 8, board columns; cursor column range 0..COLS-1.
- ROW_W, 3, cursor row width; must satisfy 2^ROW_W >= ROWS.
- COL_W, 3, cursor column width; must satisfy 2^COL_W >= COLS.
- DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rxdata  in  8  received byte; valid while rxfinish is high.
- rxfinish  in  1  level from the receiver; rises when a byte completes and stays high until the next start bit.
- cur_row  out  ROW_W  current cursor row.
- cur_col  out  COL_W  current cursor column.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_op  out  2  head opcode: 0 = OPEN, 1 = FLAG, 2 = NEWGAME (3 unused).
- cmd_row  out  ROW_W  head command row.
- cmd_col  out  COL_W  head command column.
- cmd_ready  in  1  engine accepts the head this cycle.
- overflow  out  1  sticky: a command was dropped because the FIFO was full.
- badbyte  out  1  one-cycle pulse: an unrecognised byte was received.

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high, sampled on the rising edge of clock.
  - Reset values: cur_row = 0, cur_col = 0, FIFO empty, cmd_valid = 0, cmd_op/cmd_row/cmd_col = 0, overflow = 0, badbyte = 0.
  - The rxfinish history register resets to 1, so an rxfinish already high at reset release is not treated as a new byte.
  - Reset mid-operation discards all queued commands and any in-flight byte.
- Byte detection:
  - new_byte = rxfinish & ~rxfinish_q, where rxfinish_q is rxfinish registered every cycle.
  - Exactly one decode per rising edge of rxfinish, regardless of how long it stays high.
  - rxdata is sampled in the new_byte cycle.
- Decode and latency:
  - All decode effects are registered at the clock edge that observes new_byte.
  - Effects are visible the following cycle: 1-cycle latency from rxfinish rising to cursor / cmd_valid change.
- Byte map (upper- and lower-case both accepted):
  - 'w'/'W': row -= 1, saturates at 0.
  - 's'/'S': row += 1, saturates at ROWS-1.
  - 'a'/'A': col -= 1, saturates at 0.
  - 'd'/'D': col += 1, saturates at COLS-1.
  - ' ' (0x20) or 'o'/'O': push OPEN with the current (pre-update) cursor.
  - 'f'/'F': push FLAG with the current cursor.
  - 'r'/'R': push NEWGAME with row = col = 0; cursor is set to (0,0) on the same edge.
  - Any other byte: no state change except a badbyte pulse (high exactly one cycle).
- Move commands are not queued; they only change the cursor.
- FIFO:
  - Head is shown combinationally on cmd_op/cmd_row/cmd_col while cmd_valid = 1; these outputs are 0 while empty.
  - Pop happens on an edge where cmd_valid & cmd_ready.
  - Push is accepted if count < DEPTH, or if count == DEPTH and a pop occurs on the same edge; count is then unchanged.
  - Otherwise the push is dropped and overflow is set; overflow clears only on reset.
  - Push and pop on the same edge when empty: no pop (cmd_valid is 0); the entry appears next cycle.
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
  - cmd_ready while empty is ignored.
- Invariants:
  - cur_row never exceeds ROWS-1 and cur_col never exceeds COLS-1.
  - Head fields are stable while cmd_valid = 1 and cmd_ready = 0.

Test Plan:
- Reset then send 'd','d','s' (one rxfinish rise each) -> cur_col = 2, cur_row = 1, cmd_valid stays 0.
- Hold rxfinish high 50 cycles with rxdata = 'd' -> cur_col increments exactly once; rxfinish high at reset release -> no decode.
- From (0,0) send 'w','a'; then 8x 's' with ROWS = 8 -> cursor stays (0,0) after the first two, then ends at row 7.
- Cursor (2,3), send 'o', then 'F', cmd_ready = 0 -> cmd_valid = 1, head = {OPEN,2,3}; raise cmd_ready for 2 cycles -> {FLAG,2,3}, then empty.
- cmd_ready = 0, send 5x 'f' with DEPTH = 4 -> four entries queued, overflow = 1; then push with FIFO full and cmd_ready = 1 on the same edge -> accepted, count stays 4.
- Send 'x' -> badbyte high exactly 1 cycle, cursor and FIFO unchanged; send 'r' at (5,6) -> head {NEWGAME,0,0}, cursor (0,0); assert reset with 3 entries queued -> cmd_valid = 0 next cycle, overflow = 0.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// Turns received UART keystrokes into minesweeper cursor moves and queues
// OPEN / FLAG / NEWGAME commands for the game engine.
module uart_cmd_decoder #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int ROW_W = 3,
    parameter int COL_W = 3,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       rxdata,
    input  logic             rxfinish,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic             cmd_valid,
    output logic [1:0]       cmd_op,
    output logic [ROW_W-1:0] cmd_row,
    output logic [COL_W-1:0] cmd_col,
    input  logic             cmd_ready,
    output logic             overflow,
    output logic             badbyte
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [1:0]       OP_OPEN    = 2'd0;
    localparam logic [1:0]       OP_FLAG    = 2'd1;
    localparam logic [1:0]       OP_NEWGAME = 2'd2;
    localparam logic [ROW_W-1:0] ROW_MAX    = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX    = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);

    typedef enum logic [3:0] {
        ACT_NONE, ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT,
        ACT_OPEN, ACT_FLAG, ACT_NEW, ACT_BAD
    } act_t;

    logic             rxfinish_q;
    logic             new_byte;
    act_t             act;
    logic             push;
    logic             push_ok;
    logic             pop;
    logic [1:0]       push_op;
    logic [ROW_W-1:0] push_row;
    logic [COL_W-1:0] push_col;

    logic [1:0]       mem_op  [DEPTH];
    logic [ROW_W-1:0] mem_row [DEPTH];
    logic [COL_W-1:0] mem_col [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // History resets high so a level already present at reset release is not a new byte.
    always_ff @(posedge clock) begin
        if (reset) rxfinish_q <= 1'b1;
        else       rxfinish_q <= rxfinish;
    end

    assign new_byte = rxfinish & ~rxfinish_q;

    always_comb begin
        act = ACT_NONE;
        if (new_byte) begin
            case (rxdata)
                8'h77, 8'h57:        act = ACT_UP;
                8'h73, 8'h53:        act = ACT_DOWN;
                8'h61, 8'h41:        act = ACT_LEFT;
                8'h64, 8'h44:        act = ACT_RIGHT;
                8'h20, 8'h6F, 8'h4F: act = ACT_OPEN;
                8'h66, 8'h46:        act = ACT_FLAG;
                8'h72, 8'h52:        act = ACT_NEW;
                default:             act = ACT_BAD;
            endcase
        end
    end

    always_comb begin
        push    = 1'b0;
        push_op = OP_OPEN;
        case (act)
            ACT_OPEN: begin push = 1'b1; push_op = OP_OPEN;    end
            ACT_FLAG: begin push = 1'b1; push_op = OP_FLAG;    end
            ACT_NEW:  begin push = 1'b1; push_op = OP_NEWGAME; end
            default:  ;
        endcase
    end

    assign push_row = (act == ACT_NEW) ? '0 : cur_row;
    assign push_col = (act == ACT_NEW) ? '0 : cur_col;
    assign pop      = cmd_valid & cmd_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok  = push & ((count < CNT_FULL) | pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_row <= '0;
            cur_col <= '0;
        end else begin
            case (act)
                ACT_UP:    if (cur_row != '0)     cur_row <= cur_row - 1'b1;
                ACT_DOWN:  if (cur_row < ROW_MAX) cur_row <= cur_row + 1'b1;
                ACT_LEFT:  if (cur_col != '0)     cur_col <= cur_col - 1'b1;
                ACT_RIGHT: if (cur_col < COL_MAX) cur_col <= cur_col + 1'b1;
                ACT_NEW: begin
                    cur_row <= '0;
                    cur_col <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            badbyte  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            badbyte  <= (act == ACT_BAD);
            overflow <= overflow | (push & ~push_ok);
        end
    end

    // Storage needs no reset; visibility is governed by count.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_op[wr_ptr]  <= push_op;
            mem_row[wr_ptr] <= push_row;
            mem_col[wr_ptr] <= push_col;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign cmd_valid = (count != '0);
    assign cmd_op    = cmd_valid ? mem_op[rd_ptr]  : '0;
    assign cmd_row   = cmd_valid ? mem_row[rd_ptr] : '0;
    assign cmd_col   = cmd_valid ? mem_col[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: cursor moves, saturation, edge detect,
// FIFO ordering/overflow, bad bytes, new game and reset.
module tb_uart_cmd_decoder;

    localparam int ROW_W = 3;
    localparam int COL_W = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       rxdata = 8'h00;
    logic             rxfinish = 1'b0;
    logic             cmd_ready = 1'b0;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;
    logic             overflow;
    logic             badbyte;

    int total = 0;
    int bad   = 0;

    uart_cmd_decoder #(.ROWS(8), .COLS(8), .ROW_W(ROW_W), .COL_W(COL_W), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .rxdata(rxdata), .rxfinish(rxfinish),
        .cur_row(cur_row), .cur_col(cur_col), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ready(cmd_ready),
        .overflow(overflow), .badbyte(badbyte)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        @(negedge clock); reset = 1'b0;
    endtask

    // One rxfinish rise; returns on the negedge where the decode result is visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock); rxdata = b; rxfinish = 1'b1;
        @(negedge clock); rxfinish = 1'b0;
    endtask

    task automatic test_reset();
        rxdata = "d"; rxfinish = 1'b1;
        do_reset();
        total++;
        if ({cur_row, cur_col, cmd_valid, cmd_op, cmd_row, cmd_col, overflow, badbyte} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got row=%0d col=%0d valid=%0b op=%0d hrow=%0d hcol=%0d ovf=%0b bad=%0b, need all 0",
                     cur_row, cur_col, cmd_valid, cmd_op, cmd_row, cmd_col, overflow, badbyte);
        end
        repeat (3) @(negedge clock);
        total++;
        if (cur_col !== 3'd0) begin bad++; $display("FAIL rxfinish_high_at_release: col=%0d need 0", cur_col); end
        rxfinish = 1'b0;
    endtask

    task automatic test_moves();
        do_reset();
        send_byte("d"); send_byte("d"); send_byte("s");
        total++;
        if (cur_col !== 3'd2) begin bad++; $display("FAIL moves_col: got %0d need 2", cur_col); end
        total++;
        if (cur_row !== 3'd1) begin bad++; $display("FAIL moves_row: got %0d need 1", cur_row); end
        total++;
        if (cmd_valid !== 1'b0) begin bad++; $display("FAIL moves_no_cmd: valid=%0b need 0", cmd_valid); end
    endtask

    task automatic test_hold();
        @(negedge clock); rxdata = "d"; rxfinish = 1'b1;
        repeat (50) @(negedge clock);
        rxfinish = 1'b0;
        total++;
        if (cur_col !== 3'd3) begin bad++; $display("FAIL hold_single_decode: col=%0d need 3", cur_col); end
    endtask

    task automatic test_saturate();
        do_reset();
        send_byte("w"); send_byte("a");
        total++;
        if ({cur_row, cur_col} !== 6'd0) begin bad++; $display("FAIL sat_low: row=%0d col=%0d need 0,0", cur_row, cur_col); end
        repeat (8) send_byte("s");
        total++;
        if (cur_row !== 3'd7) begin bad++; $display("FAIL sat_row_high: row=%0d need 7", cur_row); end
        repeat (9) send_byte("D");
        total++;
        if (cur_col !== 3'd7) begin bad++; $display("FAIL sat_col_high: col=%0d need 7", cur_col); end
    endtask

    task automatic test_fifo_basic();
        do_reset();
        cmd_ready = 1'b0;
        send_byte("s"); send_byte("s"); send_byte("d"); send_byte("d"); send_byte("d");
        send_byte("o"); send_byte("F");
        total++;
        if ({cmd_valid, cmd_op, cmd_row, cmd_col} !== {1'b1, 2'd0, 3'd2, 3'd3}) begin
            bad++; $display("FAIL fifo_head_open: valid=%0b op=%0d row=%0d col=%0d need 1,0,2,3", cmd_valid, cmd_op, cmd_row, cmd_col);
        end
        repeat (3) @(negedge clock);
        total++;
        if ({cmd_valid, cmd_op, cmd_row, cmd_col} !== {1'b1, 2'd0, 3'd2, 3'd3}) begin
            bad++; $display("FAIL fifo_head_stable: valid=%0b op=%0d row=%0d col=%0d need 1,0,2,3", cmd_valid, cmd_op, cmd_row, cmd_col);
        end
        cmd_ready = 1'b1;
        @(negedge clock);
        total++;
        if ({cmd_valid, cmd_op, cmd_row, cmd_col} !== {1'b1, 2'd1, 3'd2, 3'd3}) begin
            bad++; $display("FAIL fifo_head_flag: valid=%0b op=%0d row=%0d col=%0d need 1,1,2,3", cmd_valid, cmd_op, cmd_row, cmd_col);
        end
        @(negedge clock);
        cmd_ready = 1'b0;
        total++;
        if ({cmd_valid, cmd_op, cmd_row, cmd_col} !== '0) begin
            bad++; $display("FAIL fifo_empty: valid=%0b op=%0d row=%0d col=%0d need all 0", cmd_valid, cmd_op, cmd_row, cmd_col);
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        logic [1:0] first_op = 2'd3;
        logic [1:0] last_op = 2'd3;
        logic [COL_W-1:0] last_col = '0;
        do_reset();
        cmd_ready = 1'b0;
        repeat (5) send_byte("f");
        total++;
        if ({cmd_valid, overflow} !== 2'b11) begin bad++; $display("FAIL ovf_set: valid=%0b ovf=%0b need 1,1", cmd_valid, overflow); end
        send_byte("d");
        @(negedge clock); rxdata = "o"; rxfinish = 1'b1; cmd_ready = 1'b1;
        @(negedge clock); rxfinish = 1'b0; cmd_ready = 1'b0;
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: ovf=%0b need 1", overflow); end
        cmd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid) begin
                if (n == 0) first_op = cmd_op;
                last_op = cmd_op; last_col = cmd_col; n++;
            end
            @(negedge clock);
        end
        cmd_ready = 1'b0;
        total++;
        if (n !== 4) begin bad++; $display("FAIL full_push_pop_count: drained %0d need 4", n); end
        total++;
        if ({first_op, last_op, last_col} !== {2'd1, 2'd0, 3'd1}) begin
            bad++; $display("FAIL full_push_pop_order: first=%0d last=%0d lastcol=%0d need 1,0,1", first_op, last_op, last_col);
        end
        do_reset();
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_reset: ovf=%0b need 0", overflow); end
    endtask

    task automatic test_badbyte();
        do_reset();
        cmd_ready = 1'b0;
        send_byte("s"); send_byte("d"); send_byte("f");
        send_byte("x");
        total++;
        if (badbyte !== 1'b1) begin bad++; $display("FAIL badbyte_pulse: got %0b need 1", badbyte); end
        total++;
        if ({cur_row, cur_col, cmd_valid, cmd_op, cmd_row, cmd_col} !== {3'd1, 3'd1, 1'b1, 2'd1, 3'd1, 3'd1}) begin
            bad++; $display("FAIL badbyte_no_effect: row=%0d col=%0d valid=%0b op=%0d hrow=%0d hcol=%0d need 1,1,1,1,1,1",
                            cur_row, cur_col, cmd_valid, cmd_op, cmd_row, cmd_col);
        end
        @(negedge clock);
        total++;
        if (badbyte !== 1'b0) begin bad++; $display("FAIL badbyte_one_cycle: got %0b need 0", badbyte); end
        send_byte("A");
        total++;
        if ({badbyte, cur_col} !== {1'b0, 3'd0}) begin bad++; $display("FAIL valid_byte_no_bad: bad=%0b col=%0d need 0,0", badbyte, cur_col); end
    endtask

    task automatic test_newgame();
        do_reset();
        cmd_ready = 1'b0;
        repeat (5) send_byte("s");
        repeat (6) send_byte("d");
        total++;
        if ({cur_row, cur_col} !== {3'd5, 3'd6}) begin bad++; $display("FAIL ng_setup: row=%0d col=%0d need 5,6", cur_row, cur_col); end
        send_byte("r");
        total++;
        if ({cur_row, cur_col, cmd_valid, cmd_op, cmd_row, cmd_col} !== {3'd0, 3'd0, 1'b1, 2'd2, 3'd0, 3'd0}) begin
            bad++; $display("FAIL ng_head: row=%0d col=%0d valid=%0b op=%0d hrow=%0d hcol=%0d need 0,0,1,2,0,0",
                            cur_row, cur_col, cmd_valid, cmd_op, cmd_row, cmd_col);
        end
        send_byte(8'h20); send_byte("f");
        total++;
        if ({cmd_valid, cmd_op} !== {1'b1, 2'd2}) begin bad++; $display("FAIL ng_head_kept: valid=%0b op=%0d need 1,2", cmd_valid, cmd_op); end
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        total++;
        if ({cmd_valid, overflow} !== 2'b00) begin bad++; $display("FAIL reset_flush: valid=%0b ovf=%0b need 0,0", cmd_valid, overflow); end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_flush_after: valid=%0b need 0", cmd_valid); end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_hold();
        test_saturate();
        test_fifo_basic();
        test_overflow();
        test_badbyte();
        test_newgame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
